// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request arbiter: float format, op codes, FSM states.
package fpu_pkg;

  localparam int EXP_W = 7;
  localparam int MAN_W = 15;
  localparam int FW    = 1 + EXP_W + MAN_W;

  // Packed float {sign, exponent, mantissa}; hidden bit not stored.
  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } float_t;

  // Operation select latched at grant.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Arbiter FSM encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_GRANT  = 3'd1;
  localparam state_t ST_PULSE  = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_WAIT   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Request/response and FPU operand bundle between two requesters, the arbiter and the FPU.
interface fpu_req_arbiter_if;
  import fpu_pkg::*;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_sub;
  float_t [1:0] req_a;
  float_t [1:0] req_b;
  logic [1:0]   rsp_valid;
  logic         rsp_err;
  float_t       rsp_data;
  logic         busy;
  logic         fpu_add;
  logic         fpu_sub;
  float_t       fpu_a;
  float_t       fpu_b;
  float_t       fpu_res;
  logic         fpu_idle;

  // Arbiter side.
  modport slave (
    input  req_valid, req_sub, req_a, req_b, fpu_res, fpu_idle,
    output req_ready, rsp_valid, rsp_err, rsp_data, busy,
           fpu_add, fpu_sub, fpu_a, fpu_b
  );

  // Requesters plus FPU, as seen from outside the arbiter.
  modport master (
    output req_valid, req_sub, req_a, req_b, fpu_res, fpu_idle,
    input  req_ready, rsp_valid, rsp_err, rsp_data, busy,
           fpu_add, fpu_sub, fpu_a, fpu_b
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the pointer port.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Combinational one-hot (or zero) grant.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one add/sub FPU between two requesters. The winner's operands are held on the FPU
// operand registers for the whole operation; a watchdog aborts if the FPU never goes idle.
module fpu_req_arbiter
  import fpu_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  fpu_req_arbiter_if.slave bus
);

  // Terminal counts for the 8-bit settle and watchdog counters.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] WDOG_LAST   = 8'(TIMEOUT - 1);

  state_t     state_reg;
  logic       ptr_reg;
  logic       winner_reg;
  logic       op_reg;
  logic [7:0] settle_cnt_reg;
  logic [7:0] wdog_cnt_reg;
  logic [1:0] req_ready_reg;
  logic [1:0] rsp_valid_reg;
  logic       rsp_err_reg;
  float_t     rsp_data_reg;
  logic       busy_reg;
  logic       fpu_add_reg;
  logic       fpu_sub_reg;
  float_t     fpu_a_reg;
  float_t     fpu_b_reg;

  logic [1:0] grant;
  logic       win;

  rr_arb2 u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  // Index of the port the picker chose this cycle.
  assign win = grant[1];

  // Arbitration FSM with operand latches and settle/watchdog counters; strobes default low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= 1'b0;
      winner_reg     <= 1'b0;
      op_reg         <= OP_ADD;
      settle_cnt_reg <= '0;
      wdog_cnt_reg   <= '0;
      req_ready_reg  <= '0;
      rsp_valid_reg  <= '0;
      rsp_err_reg    <= 1'b0;
      rsp_data_reg   <= '0;
      busy_reg       <= 1'b0;
      fpu_add_reg    <= 1'b0;
      fpu_sub_reg    <= 1'b0;
      fpu_a_reg      <= '0;
      fpu_b_reg      <= '0;
    end else begin
      req_ready_reg <= '0;
      rsp_valid_reg <= '0;
      rsp_err_reg   <= 1'b0;
      fpu_add_reg   <= 1'b0;
      fpu_sub_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Never start while the FPU is still finishing something of its own.
          if ((|bus.req_valid) && bus.fpu_idle) begin
            winner_reg    <= win;
            req_ready_reg <= grant;
            fpu_a_reg     <= bus.req_a[win];
            fpu_b_reg     <= bus.req_b[win];
            op_reg        <= bus.req_sub[win];
            busy_reg      <= 1'b1;
            state_reg     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          state_reg <= ST_PULSE;
        end
        ST_PULSE: begin
          fpu_add_reg    <= (op_reg == OP_ADD);
          fpu_sub_reg    <= (op_reg == OP_SUB);
          settle_cnt_reg <= '0;
          state_reg      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Idle is ignored here so the FPU has time to drop it after the pulse.
          if (settle_cnt_reg == SETTLE_LAST) begin
            wdog_cnt_reg <= '0;
            state_reg    <= ST_WAIT;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 8'd1;
          end
        end
        ST_WAIT: begin
          if (bus.fpu_idle) begin
            rsp_data_reg              <= bus.fpu_res;
            rsp_valid_reg[winner_reg] <= 1'b1;
            busy_reg                  <= 1'b0;
            state_reg                 <= ST_DONE;
          end else if (wdog_cnt_reg == WDOG_LAST) begin
            rsp_err_reg               <= 1'b1;
            rsp_valid_reg[winner_reg] <= 1'b1;
            busy_reg                  <= 1'b0;
            state_reg                 <= ST_DONE;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 8'd1;
          end
        end
        ST_DONE: begin
          // Hand the next tie to the port that did not just win.
          ptr_reg   <= ~winner_reg;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.busy      = busy_reg;
  assign bus.fpu_add   = fpu_add_reg;
  assign bus.fpu_sub   = fpu_sub_reg;
  assign bus.fpu_a     = fpu_a_reg;
  assign bus.fpu_b     = fpu_b_reg;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter with a small behavioural FPU (idle drops one cycle after
// the pulse and returns after a programmable latency, or after 400 cycles when hung).
module tb_fpu_req_arbiter;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpu_req_arbiter_if bus ();

  fpu_req_arbiter #(.SETTLE(2), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // FPU model controls
  logic        m_idle;
  int          m_cnt;
  logic [22:0] m_res;
  logic [22:0] model_ret = '0;
  int          model_lat = 3;
  logic        hang = 1'b0;
  logic        hold_low = 1'b0;

  // FPU model: idle low after a pulse, result presented when idle returns
  always @(posedge clk) begin
    if (reset) begin
      m_idle <= 1'b1;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (bus.fpu_add || bus.fpu_sub) begin
      m_idle <= 1'b0;
      m_cnt  <= hang ? 399 : model_lat - 1;
    end else if (!m_idle) begin
      if (m_cnt == 0) begin
        m_idle <= 1'b1;
        m_res  <= model_ret;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign bus.fpu_idle = m_idle && !hold_low;
  assign bus.fpu_res  = m_idle ? m_res : ~model_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // add and sub pulses must never overlap
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (bus.fpu_add && bus.fpu_sub) begin
        errors++;
        $display("FAIL add_sub_overlap: add=%b sub=%b, required not both high", bus.fpu_add, bus.fpu_sub);
      end
    end
  end

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.fpu_add, bus.fpu_sub}), 32'd0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, "_fpu_a"}, 32'(bus.fpu_a), 32'd0);
    chk({tag, "_fpu_b"}, 32'(bus.fpu_b), 32'd0);
  endtask

  // One accepted transaction on a port whose req_valid is already driven.
  task automatic run_txn(input int port, input logic sub, input logic [22:0] a, input logic [22:0] b,
                         input logic [22:0] ret, input int lat, input logic exp_err);
    int n;
    int m;
    logic stable;
    logic [1:0] oh;
    oh = (port == 1) ? 2'b10 : 2'b01;
    model_ret = ret;
    model_lat = lat;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(oh));
    chk("grant_fpu_a", 32'(bus.fpu_a), 32'(a));
    chk("grant_fpu_b", 32'(bus.fpu_b), 32'(b));
    bus.req_valid[port] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.fpu_add || bus.fpu_sub) && n < 20);
    chk("pulse_delay", 32'(n), 32'd2);
    chk("pulse_op", 32'({bus.fpu_sub, bus.fpu_add}), sub ? 32'd2 : 32'd1);
    m = 0;
    stable = 1'b1;
    while (bus.rsp_valid == 2'b00 && m < 700) begin
      @(negedge clk);
      m++;
      if (23'(bus.fpu_a) != a || 23'(bus.fpu_b) != b || bus.fpu_add || bus.fpu_sub || bus.req_ready != 2'b00)
        stable = 1'b0;
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    if (!exp_err) chk("rsp_data", 32'(bus.rsp_data), 32'(ret));
    else chk("timeout_latency", 32'(m), 32'd257);
    chk("busy_at_rsp", 32'(bus.busy), 32'd0);
    chk("held_during_op", 32'(stable), 32'd1);
    $display("txn port=%0d op=%s a=%h b=%h data=%h err=%0b", port, sub ? "sub" : "add", a, b,
             bus.rsp_data, bus.rsp_err);
    @(negedge clk);
    chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [1:0]       valid;
    logic [1:0]       sub;
    logic [1:0][22:0] a;
    logic [1:0][22:0] b;
    logic [1:0][22:0] r;
    int               first;
    int               lat;
  } vec_t;

  vec_t vt[5];

  initial begin
    int n;
    int f;
    int o;
    logic quiet;

    // {valid, sub, a, b, result, expected first winner, FPU latency}; pointer starts at port 0
    vt[0] = '{2'b11, 2'b00, {23'h123456, 23'h404000}, {23'h054321, 23'h404000},
              {23'h0abcde, 23'h414000}, 0, 3};                   // tie after reset -> 0, 1
    vt[1] = '{2'b01, 2'b01, {23'h000000, 23'h3f8000}, {23'h000000, 23'h3f0000},
              {23'h000000, 23'h3e8000}, 0, 4};                   // lone port 0 -> ptr 1
    vt[2] = '{2'b11, 2'b10, {23'h2a0001, 23'h150002}, {23'h011111, 23'h022222},
              {23'h333333, 23'h444444}, 1, 2};                   // tie, ptr 1 -> 1, 0
    vt[3] = '{2'b10, 2'b00, {23'h7fffff, 23'h000000}, {23'h000001, 23'h000000},
              {23'h555555, 23'h000000}, 1, 1};                   // lone port 1 -> ptr 0
    vt[4] = '{2'b11, 2'b11, {23'h600000, 23'h0f0f0f}, {23'h00ff00, 23'h70f0f0},
              {23'h666666, 23'h777777}, 0, 5};                   // tie, ptr 0 -> 0, 1

    bus.req_valid = '0;
    bus.req_sub   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      bus.req_a     = vt[i].a;
      bus.req_b     = vt[i].b;
      bus.req_sub   = vt[i].sub;
      bus.req_valid = vt[i].valid;
      f = vt[i].first;
      o = 1 - f;
      run_txn(f, vt[i].sub[f], vt[i].a[f], vt[i].b[f], vt[i].r[f], vt[i].lat, 1'b0);
      if (vt[i].valid[o])
        run_txn(o, vt[i].sub[o], vt[i].a[o], vt[i].b[o], vt[i].r[o], vt[i].lat, 1'b0);
    end

    // Port 1 sub in flight, port 0 requests mid-operation with different operands
    bus.req_a[1]     = 23'h4c0000;
    bus.req_b[1]     = 23'h0c0000;
    bus.req_sub[1]   = 1'b1;
    bus.req_valid[1] = 1'b1;
    fork
      run_txn(1, 1'b1, 23'h4c0000, 23'h0c0000, 23'h123123, 6, 1'b0);
      begin
        repeat (6) @(negedge clk);
        bus.req_a[0]     = 23'h5a5a5a;
        bus.req_b[0]     = 23'h25a5a5;
        bus.req_sub[0]   = 1'b0;
        bus.req_valid[0] = 1'b1;
      end
    join
    run_txn(0, 1'b0, 23'h5a5a5a, 23'h25a5a5, 23'h7e7e7e, 3, 1'b0);

    // FPU reports busy while a request waits in IDLE
    hold_low = 1'b1;
    bus.req_a[0]     = 23'h010203;
    bus.req_b[0]     = 23'h040506;
    bus.req_sub[0]   = 1'b1;
    bus.req_valid[0] = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00 || bus.busy) quiet = 1'b0;
    end
    chk("no_grant_fpu_busy", 32'(quiet), 32'd1);
    hold_low = 1'b0;
    run_txn(0, 1'b1, 23'h010203, 23'h040506, 23'h070809, 2, 1'b0);

    // FPU hangs: watchdog abort, then the next request is still served
    hang = 1'b1;
    bus.req_a[1]     = 23'h111111;
    bus.req_b[1]     = 23'h222222;
    bus.req_sub[1]   = 1'b0;
    bus.req_valid[1] = 1'b1;
    run_txn(1, 1'b0, 23'h111111, 23'h222222, 23'h0, 3, 1'b1);
    hang = 1'b0;
    bus.req_a[0]     = 23'h3c3c3c;
    bus.req_b[0]     = 23'h434343;
    bus.req_sub[0]   = 1'b0;
    bus.req_valid[0] = 1'b1;
    run_txn(0, 1'b0, 23'h3c3c3c, 23'h434343, 23'h2b2b2b, 3, 1'b0);

    // Reset during WAIT with the pointer at port 1
    model_lat = 20;
    bus.req_a[1]     = 23'h6d6d6d;
    bus.req_b[1]     = 23'h1e1e1e;
    bus.req_sub[1]   = 1'b1;
    bus.req_valid[1] = 1'b1;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_txn_ready", 32'(bus.req_ready), 32'd2);
    bus.req_valid[1] = 1'b0;
    n = 0;
    while (!(bus.fpu_add || bus.fpu_sub) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_txn_pulse", 32'({bus.fpu_sub, bus.fpu_add}), 32'd2);
    repeat (4) @(negedge clk);
    chk("rst_txn_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_outs_zero("mid_reset");
    reset = 1'b0;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00 || bus.req_ready != 2'b00) quiet = 1'b0;
    end
    chk("no_rsp_after_reset", 32'(quiet), 32'd1);
    bus.req_a   = {23'h0a0a0a, 23'h050505};
    bus.req_b   = {23'h0b0b0b, 23'h060606};
    bus.req_sub = 2'b00;
    bus.req_valid = 2'b11;
    run_txn(0, 1'b0, 23'h050505, 23'h060606, 23'h090909, 3, 1'b0);
    run_txn(1, 1'b0, 23'h0a0a0a, 23'h0b0b0b, 23'h0c0c0c, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
